// File: rtl/hazard_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// hazard_sequencer_pkg
//   Shared types and constants for the pipeline hazard sequencer.
//   - state_t : sequencer state encoding (RUN / BUBBLE / FREEZE)
//   - mode_t  : output mode selected for the current cycle
//   - REG_W   : register-number width
//   - ZERO_REG: hard-wired zero register ($0), which never creates a hazard
// -----------------------------------------------------------------------------
package hazard_sequencer_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] ZERO_REG = '0;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_BUBBLE = 2'd1,
      ST_FREEZE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      MODE_NORMAL  = 2'd0,
      MODE_STALL   = 2'd1,
      MODE_BRFLUSH = 2'd2,
      MODE_FREEZE  = 2'd3
   } mode_t;

endpackage

// File: rtl/hazard_sequencer_if.sv
// -----------------------------------------------------------------------------
// hazard_sequencer_if
//   Bundles the hazard inputs (register fields and pipeline status from
//   ID/EX/MEM) and the pipeline-register control outputs.
//   modport master : pipeline side - drives hazard inputs, receives controls
//   modport slave  : hazard sequencer - receives hazard inputs, drives controls
// -----------------------------------------------------------------------------
interface hazard_sequencer_if;
   import hazard_sequencer_pkg::*;

   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_uses_rt;
   logic [REG_W-1:0] ex_rt;
   logic             ex_memread;
   logic             mem_branch_taken;
   logic             mem_busy;

   logic pc_write_en;
   logic ifid_write_en;
   logic ifid_flush;
   logic idex_write_en;
   logic idex_ctrl_flush;
   logic idex_beq_flush;
   logic exmem_write_en;
   logic stalled;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_rt, ex_memread, mem_branch_taken, mem_busy,
      input  pc_write_en, ifid_write_en, ifid_flush, idex_write_en,
             idex_ctrl_flush, idex_beq_flush, exmem_write_en, stalled
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_rt, ex_memread, mem_branch_taken, mem_busy,
      output pc_write_en, ifid_write_en, ifid_flush, idex_write_en,
             idex_ctrl_flush, idex_beq_flush, exmem_write_en, stalled
   );

endinterface

// File: rtl/hazard_sequencer_stat_counters.sv
// -----------------------------------------------------------------------------
// hazard_stat_counters
//   Three 32-bit saturating event counters, cleared by the asynchronous reset.
//   Only instantiated when HAZARD_STATS_EN is defined.
//   Ports:
//     clk    : clock, rising edge
//     rst    : asynchronous active-high reset, clears all counters
//     inc    : per-counter increment strobe, [0]=stall [1]=flush [2]=freeze
//     counts : counter values, counts[i] pairs with inc[i]
// -----------------------------------------------------------------------------
module hazard_stat_counters (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       inc,
   output logic [2:0][31:0] counts
);

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
         logic [31:0] count_reg;

         // Saturate at all-ones instead of wrapping back to zero.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               count_reg <= '0;
            end else if (inc[gi] && (count_reg != '1)) begin
               count_reg <= count_reg + 32'd1;
            end
         end

         assign counts[gi] = count_reg;
      end
   endgenerate

endmodule

// File: rtl/hazard_sequencer.sv
// -----------------------------------------------------------------------------
// hazard_sequencer
//   Hazard controller for the 5-stage MIPS pipeline. Generates write-enable and
//   flush controls for PC, IF/ID, ID/EX and EX/MEM from three hazard classes:
//   load-use (LOAD_BUBBLES bubbles), taken branch resolved in MEM, and
//   data-memory busy (whole-pipeline freeze).
//   Priority per cycle: mem_busy > mem_branch_taken > load-use / bubble.
//   Outputs are Mealy: registered state plus current inputs.
//
//   Parameters:
//     LOAD_BUBBLES : bubble cycles per load-use hazard (1..7)
//     CNT_W        : width of the bubble counter
//   Ports:
//     clk, rst : clock (rising edge), asynchronous active-high reset
//     hz       : hazard_sequencer_if.slave - hazard inputs and control outputs
//   Optional (macro HAZARD_STATS_EN):
//     stat_stall_cycles, stat_flushes, stat_freeze_cycles : 32-bit saturating
//     event counters for STALL, BRFLUSH and FREEZE cycles.
// -----------------------------------------------------------------------------
module hazard_sequencer
   import hazard_sequencer_pkg::*;
#(
   parameter int LOAD_BUBBLES = 1,
   parameter int CNT_W        = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   hazard_sequencer_if.slave    hz
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]          stat_stall_cycles,
   output logic [31:0]          stat_flushes,
   output logic [31:0]          stat_freeze_cycles
`endif
);

   state_t           state_reg, state_next;
   state_t           saved_reg, saved_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   state_t           active_state;
   mode_t            mode;
   logic             load_use;

   assign load_use = hz.ex_memread && (hz.ex_rt != ZERO_REG) &&
                     ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

   // Leaving FREEZE acts in the same cycle as the saved state would, so the
   // decision logic below works on the resumed state rather than FREEZE.
   assign active_state = (state_reg == ST_FREEZE) ? saved_reg : state_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_RUN;
         saved_reg <= ST_RUN;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         saved_reg <= saved_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      mode       = MODE_NORMAL;
      state_next = state_reg;
      saved_next = saved_reg;
      cnt_next   = cnt_reg;
      if (hz.mem_busy) begin
         // The counter is left untouched so a frozen bubble sequence resumes
         // exactly where it stopped.
         mode = MODE_FREEZE;
         if (state_reg != ST_FREEZE) begin
            saved_next = state_reg;
            state_next = ST_FREEZE;
         end
      end else begin
         saved_next = ST_RUN;
         case (active_state)
            ST_RUN: begin
               state_next = ST_RUN;
               if (hz.mem_branch_taken) begin
                  // The younger load-dependent instruction is discarded anyway.
                  mode = MODE_BRFLUSH;
               end else if (load_use) begin
                  mode = MODE_STALL;
                  if (LOAD_BUBBLES > 1) begin
                     cnt_next   = CNT_W'(LOAD_BUBBLES - 1);
                     state_next = ST_BUBBLE;
                  end
               end
            end
            ST_BUBBLE: begin
               // A load-use seen here is ignored: EX holds a bubble.
               if (hz.mem_branch_taken) begin
                  mode       = MODE_BRFLUSH;
                  cnt_next   = '0;
                  state_next = ST_RUN;
               end else begin
                  mode = MODE_STALL;
                  if (cnt_reg == CNT_W'(1)) begin
                     state_next = ST_RUN;
                  end else begin
                     cnt_next   = cnt_reg - CNT_W'(1);
                     state_next = ST_BUBBLE;
                  end
               end
            end
            default: begin
               cnt_next   = '0;
               state_next = ST_RUN;
            end
         endcase
      end
   end

   always_comb begin
      hz.pc_write_en     = 1'b1;
      hz.ifid_write_en   = 1'b1;
      hz.ifid_flush      = 1'b0;
      hz.idex_write_en   = 1'b1;
      hz.idex_ctrl_flush = 1'b0;
      hz.idex_beq_flush  = 1'b0;
      hz.exmem_write_en  = 1'b1;
      hz.stalled         = 1'b0;
      case (mode)
         MODE_STALL: begin
            hz.pc_write_en     = 1'b0;
            hz.ifid_write_en   = 1'b0;
            hz.idex_ctrl_flush = 1'b1;
            hz.stalled         = 1'b1;
         end
         MODE_BRFLUSH: begin
            hz.ifid_flush     = 1'b1;
            hz.idex_beq_flush = 1'b1;
         end
         MODE_FREEZE: begin
            hz.pc_write_en    = 1'b0;
            hz.ifid_write_en  = 1'b0;
            hz.idex_write_en  = 1'b0;
            hz.exmem_write_en = 1'b0;
            hz.stalled        = 1'b1;
         end
         default: ;
      endcase
      // Reset holds the whole pipeline without waiting for a clock edge.
      if (rst) begin
         hz.pc_write_en     = 1'b0;
         hz.ifid_write_en   = 1'b0;
         hz.ifid_flush      = 1'b0;
         hz.idex_write_en   = 1'b0;
         hz.idex_ctrl_flush = 1'b0;
         hz.idex_beq_flush  = 1'b0;
         hz.exmem_write_en  = 1'b0;
         hz.stalled         = 1'b1;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [2:0]       stat_inc;
   logic [2:0][31:0] stat_counts;

   assign stat_inc = {mode == MODE_FREEZE, mode == MODE_BRFLUSH, mode == MODE_STALL};

   hazard_stat_counters u_stats (
      .clk    (clk),
      .rst    (rst),
      .inc    (stat_inc),
      .counts (stat_counts)
   );

   assign stat_stall_cycles  = stat_counts[0];
   assign stat_flushes       = stat_counts[1];
   assign stat_freeze_cycles = stat_counts[2];
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hazard_sequencer
//   Drives two sequencers (LOAD_BUBBLES=1 and 3) with identical stimulus and
//   compares every cycle against a reference that tracks the number of owed
//   bubble cycles. Directed scenarios first, then randomized traffic.
//   Define HAZARD_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_hazard_sequencer;

   localparam int M_NRM = 0;
   localparam int M_STL = 1;
   localparam int M_BR  = 2;
   localparam int M_FRZ = 3;
   localparam int M_RST = 4;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic id_uses_rt, ex_memread, mem_branch_taken, mem_busy;

   int checks = 0;
   int errors = 0;
   int step_no = 0;
   int left [2];
   int lb [2] = '{1, 3};
   int exp_stat [2][3];

   always #5 clk = ~clk;

   hazard_sequencer_if bus1();
   hazard_sequencer_if bus3();

   assign bus1.id_rs = id_rs;            assign bus3.id_rs = id_rs;
   assign bus1.id_rt = id_rt;            assign bus3.id_rt = id_rt;
   assign bus1.id_uses_rt = id_uses_rt;  assign bus3.id_uses_rt = id_uses_rt;
   assign bus1.ex_rt = ex_rt;            assign bus3.ex_rt = ex_rt;
   assign bus1.ex_memread = ex_memread;  assign bus3.ex_memread = ex_memread;
   assign bus1.mem_branch_taken = mem_branch_taken;
   assign bus3.mem_branch_taken = mem_branch_taken;
   assign bus1.mem_busy = mem_busy;      assign bus3.mem_busy = mem_busy;

`ifdef HAZARD_STATS_EN
   logic [31:0] s1_stall, s1_flush, s1_freeze;
   logic [31:0] s3_stall, s3_flush, s3_freeze;
`endif

   hazard_sequencer #(.LOAD_BUBBLES(1), .CNT_W(3)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .hz  (bus1.slave)
`ifdef HAZARD_STATS_EN
      ,
      .stat_stall_cycles  (s1_stall),
      .stat_flushes       (s1_flush),
      .stat_freeze_cycles (s1_freeze)
`endif
   );

   hazard_sequencer #(.LOAD_BUBBLES(3), .CNT_W(3)) u_dut3 (
      .clk (clk),
      .rst (rst),
      .hz  (bus3.slave)
`ifdef HAZARD_STATS_EN
      ,
      .stat_stall_cycles  (s3_stall),
      .stat_flushes       (s3_flush),
      .stat_freeze_cycles (s3_freeze)
`endif
   );

   // Required control pattern per mode:
   // {pc_we, ifid_we, ifid_flush, idex_we, ctrl_flush, beq_flush, exmem_we, stalled}
   function automatic logic [7:0] mode_vec(input int m);
      case (m)
         M_NRM:   return 8'b1101_0010;
         M_STL:   return 8'b0001_1011;
         M_BR:    return 8'b1111_0110;
         default: return 8'b0000_0001;
      endcase
   endfunction

   function automatic logic load_use_ref();
      return ex_memread && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   endfunction

   // Reference: left[k] is the number of stall cycles still owed.
   function automatic int exp_mode(input int k);
      if (rst) return M_RST;
      if (mem_busy) return M_FRZ;
      if (mem_branch_taken) return M_BR;
      if (left[k] > 0) return M_STL;
      if (load_use_ref()) return M_STL;
      return M_NRM;
   endfunction

   function automatic logic [7:0] obs_vec(input int k);
      if (k == 0)
         return {bus1.pc_write_en, bus1.ifid_write_en, bus1.ifid_flush, bus1.idex_write_en,
                 bus1.idex_ctrl_flush, bus1.idex_beq_flush, bus1.exmem_write_en, bus1.stalled};
      return {bus3.pc_write_en, bus3.ifid_write_en, bus3.ifid_flush, bus3.idex_write_en,
              bus3.idex_ctrl_flush, bus3.idex_beq_flush, bus3.exmem_write_en, bus3.stalled};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called shortly after a falling edge with inputs already applied.
   task automatic step(input string tag);
      int m [2];
      #1;
      step_no++;
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            left[k] = 0;
            for (int j = 0; j < 3; j++) exp_stat[k][j] = 0;
         end
      end
      for (int k = 0; k < 2; k++) begin
         m[k] = exp_mode(k);
         check($sformatf("%s#%0d lb%0d ctrl", tag, step_no, lb[k]), 32'(obs_vec(k)), 32'(mode_vec(m[k])));
      end
`ifdef HAZARD_STATS_EN
      check($sformatf("%s#%0d lb1 stall_cnt", tag, step_no), s1_stall, exp_stat[0][0]);
      check($sformatf("%s#%0d lb1 flush_cnt", tag, step_no), s1_flush, exp_stat[0][1]);
      check($sformatf("%s#%0d lb1 freeze_cnt", tag, step_no), s1_freeze, exp_stat[0][2]);
      check($sformatf("%s#%0d lb3 stall_cnt", tag, step_no), s3_stall, exp_stat[1][0]);
      check($sformatf("%s#%0d lb3 flush_cnt", tag, step_no), s3_flush, exp_stat[1][1]);
      check($sformatf("%s#%0d lb3 freeze_cnt", tag, step_no), s3_freeze, exp_stat[1][2]);
`endif
      $display("step %0d %s rst=%0b busy=%0b br=%0b rd=%0b ex_rt=%0d rs=%0d rt=%0d/%0b | lb1=%b lb3=%b",
               step_no, tag, rst, mem_busy, mem_branch_taken, ex_memread, ex_rt, id_rs, id_rt,
               id_uses_rt, obs_vec(0), obs_vec(1));
      // Advance the reference to the state after the coming rising edge.
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            case (m[k])
               M_BR:  begin left[k] = 0; exp_stat[k][1]++; end
               M_FRZ: exp_stat[k][2]++;
               M_STL: begin
                  if (left[k] > 0) left[k]--;
                  else left[k] = lb[k] - 1;
                  exp_stat[k][0]++;
               end
               default: ;
            endcase
         end
      end
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      ex_memread = 0; mem_branch_taken = 0; mem_busy = 0;
      id_uses_rt = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
   endtask

   task automatic ld_use(input logic [4:0] r);
      idle();
      ex_memread = 1; ex_rt = r; id_rs = r;
   endtask

   initial begin
      logic [4:0] regs [4];
      regs = '{5'd0, 5'd8, 5'd9, 5'd31};
      rst = 1;
      idle();
      for (int k = 0; k < 2; k++) begin
         left[k] = 0;
         for (int j = 0; j < 3; j++) exp_stat[k][j] = 0;
      end
      @(negedge clk);
      #1;
      step("reset");
      rst = 0;
      step("idle");

      // Load-use: LB=1 stalls once, LB=3 stalls three times.
      ld_use(5'd8);       step("load_use");
      idle();             step("after_lu1");
      step("after_lu2");
      step("after_lu3");

      // Zero register never stalls.
      ld_use(5'd0);       step("zero_reg");

      // rt dependency only when the ID instruction reads rt.
      idle(); ex_memread = 1; ex_rt = 9; id_rt = 9; id_uses_rt = 1; step("rt_use");
      idle(); step("rt_drain1"); step("rt_drain2");
      ex_memread = 1; ex_rt = 9; id_rt = 9; id_uses_rt = 0; step("rt_nouse");

      // Branch wins over a simultaneous load-use.
      ld_use(5'd8); mem_branch_taken = 1; step("br_over_lu");
      idle(); step("after_br");

      // Freeze during the second bubble.
      ld_use(5'd8);       step("frz_lu");
      idle(); mem_busy = 1;
      for (int i = 0; i < 4; i++) step("frz_busy");
      mem_busy = 0;
      for (int i = 0; i < 3; i++) step("frz_resume");

      // Branch cancels pending bubbles.
      ld_use(5'd8);       step("brb_lu");
      idle(); mem_branch_taken = 1; step("brb_branch");
      idle(); step("brb_after");

      // Continuous load-use: the request seen during bubbles is ignored.
      ld_use(5'd9);
      for (int i = 0; i < 5; i++) step("lu_hold");
      idle(); step("lu_hold_end"); step("lu_hold_end");

      // Asynchronous reset in the middle of a freeze and of a bubble.
      ld_use(5'd8);       step("rst_lu");
      idle(); mem_busy = 1; step("rst_busy"); step("rst_busy");
      #2 rst = 1;         step("rst_mid_frz");
      rst = 0; mem_busy = 0; step("rst_release");
      ld_use(5'd8);       step("rst_lu2");
      idle(); #2 rst = 1; step("rst_mid_bub");
      rst = 0;            step("rst_release2");

`ifdef HAZARD_STATS_EN
      // 2 load-use hazards, 1 branch, 3 busy cycles.
      rst = 1; step("st_rst");
      rst = 0; idle(); step("st_idle");
      ld_use(5'd8); step("st_lu"); idle(); step("st_gap"); step("st_gap"); step("st_gap");
      ld_use(5'd9); step("st_lu"); idle(); step("st_gap"); step("st_gap"); step("st_gap");
      mem_branch_taken = 1; step("st_br");
      idle(); mem_busy = 1; step("st_busy"); step("st_busy"); step("st_busy");
      idle(); step("st_end");
      check("stat_stall_lb1", s1_stall, 32'd2);
      check("stat_flush_lb1", s1_flush, 32'd1);
      check("stat_freeze_lb1", s1_freeze, 32'd3);
`endif

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         rst              = ($urandom_range(0, 99) < 2);
         ex_memread       = ($urandom_range(0, 99) < 50);
         mem_branch_taken = ($urandom_range(0, 99) < 12);
         mem_busy         = ($urandom_range(0, 99) < 15);
         id_uses_rt       = $urandom_range(0, 1);
         ex_rt            = regs[$urandom_range(0, 3)];
         id_rs            = regs[$urandom_range(0, 3)];
         id_rt            = regs[$urandom_range(0, 3)];
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline hazard controller for the 5-stage MIPS core. It generates the write-enable and flush controls for PC, IF/ID, ID/EX and EX/MEM.
- It handles three hazard classes:
  - load-use hazards, with a configurable number of bubbles;
  - taken branches resolved in MEM;
  - data-memory busy freezes.
- It sits beside the ID stage and drives the IDEX_WriteEn, IDEX_CtrlFlush and IDEX_BeqFlush inputs of the ID/EX register.

Parameters:
- LOAD_BUBBLES, 1, number of bubble cycles inserted per load-use hazard (1..7).
- CNT_W, 3, width of the internal bubble counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
- ex_rt  in  5  rt of instruction in EX (load destination)
- ex_memread  in  1  EX instruction is a load
- mem_branch_taken  in  1  branch in MEM resolved taken
- mem_busy  in  1  data memory not ready; whole pipeline must hold
- pc_write_en  out  1  PC update enable
- ifid_write_en  out  1  IF/ID write enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_write_en  out  1  drives IDEX_WriteEn
- idex_ctrl_flush  out  1  drives IDEX_CtrlFlush (bubble)
- idex_beq_flush  out  1  drives IDEX_BeqFlush (full clear)
- exmem_write_en  out  1  EX/MEM write enable
- stalled  out  1  any of PC/IF/ID held this cycle

Behaviour:
- Reset and resume state
  - Reset is asynchronous, active-high, on clk.
  - While rst=1: state=RUN, bubble count=0, saved state=RUN.
  - Outputs during reset: all *_write_en=0, all flushes=0, stalled=1.
- Output timing
  - Outputs are combinational (Mealy) from registered state plus current inputs, so they act in the same cycle the hazard is detected.
  - State is registered.
- load_use = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- Output modes:
  - NORMAL: all write_en=1, flushes=0.
  - STALL: pc_write_en=0, ifid_write_en=0, idex_write_en=1, idex_ctrl_flush=1, exmem_write_en=1, stalled=1.
  - BRFLUSH: all write_en=1, ifid_flush=1, idex_beq_flush=1, idex_ctrl_flush=0, stalled=0.
  - FREEZE: all write_en=0, all flushes=0, stalled=1.
- States: RUN, BUBBLE, FREEZE. Priority within a cycle: mem_busy > mem_branch_taken > load_use / bubble.
- RUN:
  - mem_busy: mode FREEZE, save RUN, go to FREEZE.
  - Else mem_branch_taken: mode BRFLUSH, stay RUN. The branch overrides a simultaneous load_use, because the younger instruction is discarded.
  - Else load_use: mode STALL. If LOAD_BUBBLES>1, load cnt=LOAD_BUBBLES-1 and go to BUBBLE; else stay RUN.
  - Else: mode NORMAL.
- BUBBLE:
  - mem_busy: mode FREEZE, save BUBBLE; cnt is held; go to FREEZE.
  - Else mem_branch_taken: mode BRFLUSH, cnt=0, go to RUN.
  - Else: mode STALL, cnt decrements; when cnt==1 go to RUN.
- FREEZE:
  - mem_busy=1: mode FREEZE, hold state.
  - mem_busy=0: behave in that same cycle exactly as the saved state, with its saved cnt, including its transitions. There is no extra dead cycle.
- Boundaries
  - ex_rt==0 never stalls.
  - A load_use arising in BUBBLE is ignored, because the instruction in EX is a bubble.
  - Counter never wraps; cnt never decrements below 1.
  - Asserting rst mid-BUBBLE or mid-FREEZE returns to RUN immediately and discards the saved state.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds outputs stat_stall_cycles, stat_flushes and stat_freeze_cycles, each 32 bits, saturating at all-ones.
  - stat_stall_cycles increments on STALL cycles.
  - stat_flushes increments on BRFLUSH cycles.
  - stat_freeze_cycles increments on FREEZE cycles.
  - All three are cleared by rst.
- Undefined: none of these ports or counters exist.

Decomposition:
- Shared package:
  - state encoding enum (RUN=2'd0, BUBBLE=2'd1, FREEZE=2'd2);
  - register-number width constant (5);
  - zero-register constant.
- One natural sub-module, hazard_stat_counters: the three saturating counters, instantiated only under HAZARD_STATS_EN.

Test Plan:
- Load-use, LOAD_BUBBLES=1: ex_memread=1, ex_rt=8, id_rs=8 -> exactly one cycle of pc_write_en=0, idex_ctrl_flush=1; NORMAL the next cycle.
- Load-use, LOAD_BUBBLES=3: same stimulus for one cycle, then ex_memread=0 -> STALL held 3 cycles, then NORMAL; ex_rt=0 with id_rs=0 -> no stall.
- Branch over load-use: mem_branch_taken=1 while load_use=1 -> ifid_flush=1, idex_beq_flush=1, pc_write_en=1, idex_ctrl_flush=0.
- Freeze in BUBBLE (LOAD_BUBBLES=3): mem_busy high for 4 cycles during the 2nd bubble -> all enables 0 for 4 cycles, then remaining 2 STALL cycles, then NORMAL.
- Async reset mid-FREEZE: rst pulsed between clock edges -> outputs go to the reset values immediately; after release with no hazards -> NORMAL.
- HAZARD_STATS_EN: 2 load-use hazards, 1 branch and 3 busy cycles -> stat_stall_cycles=2, stat_flushes=1, stat_freeze_cycles=3.
